// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, branch redirect
// and the decode-side handshake.
//   master : the fetch unit (drives requests and the decode payload)
//   slave  : memory / control / decode environment
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  Op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        output dec_valid, dec_instr, dec_pc, Op, funct3, funct7,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  dec_valid, dec_instr, dec_pc, Op, funct3, funct7,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. Keeps the PC, issues in-order word fetches under
// a credit limit, buffers returned words with their PCs and hands them to decode.
// A redirect restarts fetch at a new PC, flushes the buffer and drops every
// response still in flight.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - instr_fetch_unit_if.master (imem req/rsp, redirect, decode handshake)
// Build option:
//   FETCH_BYPASS_EN - when defined, a response that meets an empty buffer and a
//                     ready decoder is forwarded to decode in the same cycle.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.master    bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] drop_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];

    logic             req_valid;
    logic             req_fire;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      rsp_pc;
    logic             rsp_keep;
    logic             bypass;
    logic             push;
    logic             head_valid;
    logic             pop;
    logic [31:0]      dec_instr;
    logic [CNT_W-1:0] inflight_next;

    wire unused_rpc_lsb = &{1'b0, bus.redirect_pc[1:0]};

    // Credit: never have more words in flight or buffered than the buffer holds.
    assign credit_used = (CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count);
    assign req_valid   = rst && !bus.redirect_valid && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;

    // Once the drop count is zero every in-flight request belongs to the current
    // stream, so the oldest one was issued outstanding words before the PC.
    assign rsp_pc   = pc - (32'(outstanding) << 2);
    assign rsp_keep = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;

`ifdef FETCH_BYPASS_EN
    // Empty buffer and a ready decoder: forward the response straight through.
    assign bypass = rsp_keep && (fifo_count == '0) && bus.dec_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push       = rsp_keep && !bypass;
    assign head_valid = (fifo_count != '0) && !bus.redirect_valid;
    assign pop        = head_valid && bus.dec_ready;

    assign inflight_next = outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);

    // Decode payload: bypassed response, else buffer head, else NOP.
    always_comb begin
        dec_instr  = NOP;
        bus.dec_pc = 32'h0;
        if (bypass) begin
            dec_instr  = bus.imem_rsp_data;
            bus.dec_pc = rsp_pc;
        end else if (head_valid) begin
            dec_instr  = fifo_instr[rd_ptr];
            bus.dec_pc = fifo_pc[rd_ptr];
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.dec_valid      = head_valid || bypass;
    assign bus.dec_instr      = dec_instr;
    assign bus.Op             = dec_instr[6:0];
    assign bus.funct3         = dec_instr[14:12];
    assign bus.funct7         = dec_instr[31:25];

    // PC, credit and buffer bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= inflight_next;
            if (bus.redirect_valid) begin
                pc         <= {bus.redirect_pc[31:2], 2'b00};
                drop_cnt   <= inflight_next;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Buffer storage; contents are qualified by fifo_count so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end
endmodule
